// File: rtl/mem_wb_pkg.sv
// Shared types and defaults for the MEM/WB skid stage.
//   occ_t      : occupancy of the two-entry buffer (EMPTY / ONE / FULL)
//   entry_t    : one pipeline entry at the default widths
//   wb_value() : write-back value an entry would produce
package mem_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [DATA_W_DEF-1:0] mem_data;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [REG_AW_DEF-1:0] rd;
  } entry_t;

  function automatic logic [DATA_W_DEF-1:0] wb_value(entry_t e);
    return e.mem_to_reg ? e.mem_data : e.alu_result;
  endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// One forwarding query port compared against the head (older) and skid
// (younger) entries of the MEM/WB stage.
//   rs            : queried source register
//   h_* / s_*     : valid, reg_write, rd and write-back value of each entry
//   hit           : some held entry will write rs
//   data          : value of the youngest matching entry, 0 without a hit
module wb_fwd_match #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              h_valid,
  input  logic              h_reg_write,
  input  logic [REG_AW-1:0] h_rd,
  input  logic [DATA_W-1:0] h_wb_data,
  input  logic              s_valid,
  input  logic              s_reg_write,
  input  logic [REG_AW-1:0] s_rd,
  input  logic [DATA_W-1:0] s_wb_data,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic h_match;
  logic s_match;

  // Register 0 is hard-wired to zero, so a write to it is never forwarded.
  assign h_match = h_valid && h_reg_write && (h_rd != '0) && (h_rd == rs);
  assign s_match = s_valid && s_reg_write && (s_rd != '0) && (s_rd == rs);

  assign hit = h_match | s_match;

  // The skid entry is younger, so its value supersedes the head's.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    data = '0;
    if (s_match)      data = s_wb_data;
    else if (h_match) data = h_wb_data;
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline stage with a two-entry skid buffer (head H, skid S),
// synchronous flush and register-forwarding match logic.
//   clk, reset_n          : clock; asynchronous active-low reset
//   in_valid / in_ready   : upstream handshake; in_ready is low only when FULL
//   in_*                  : incoming entry fields
//   flush                 : empty the stage, dropping the same-cycle input
//   out_valid / out_ready : write-back handshake on the head entry
//   out_*, wb_data        : head-entry fields, all zero while out_valid=0
//   fwd_rs/fwd_hit/fwd_data : NUM_FWD packed forwarding query ports
module mem_wb_skid_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_reg_write,
  input  logic                      in_mem_to_reg,
  input  logic [DATA_W-1:0]         in_mem_data,
  input  logic [DATA_W-1:0]         in_alu_result,
  input  logic [REG_AW-1:0]         in_rd,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_reg_write,
  output logic                      out_mem_to_reg,
  output logic [DATA_W-1:0]         out_mem_data,
  output logic [DATA_W-1:0]         out_alu_result,
  output logic [REG_AW-1:0]         out_rd,
  output logic [DATA_W-1:0]         wb_data,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rs,
  output logic [NUM_FWD-1:0]        fwd_hit,
  output logic [NUM_FWD*DATA_W-1:0] fwd_data
);

  // Payload of one entry; validity lives in the occupancy state.
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_AW-1:0] rd;
  } stage_entry_t;

  occ_t         occ_q, occ_d;
  stage_entry_t h_q, s_q, in_entry;
  logic         h_valid, s_valid;
  logic         accept, pop;
  logic         load_h_in, load_h_skid, load_s;
  logic [DATA_W-1:0] h_wb, s_wb;

  assign in_entry = '{reg_write:  in_reg_write,
                      mem_to_reg: in_mem_to_reg,
                      mem_data:   in_mem_data,
                      alu_result: in_alu_result,
                      rd:         in_rd};

  assign h_valid = (occ_q != EMPTY);
  assign s_valid = (occ_q == FULL);

  // Both handshake signals come straight from the state register.
  assign in_ready  = !s_valid;
  assign out_valid = h_valid;

  assign accept = in_valid & in_ready;
  assign pop    = h_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) occ_q <= EMPTY;
    else          occ_q <= occ_d;
  end

  always_comb begin
    occ_d       = occ_q;
    load_h_in   = 1'b0;
    load_h_skid = 1'b0;
    load_s      = 1'b0;
    if (flush) begin
      // A same-cycle pop has already been taken by write-back; the input is dropped.
      occ_d = EMPTY;
    end else begin
      case (occ_q)
        EMPTY: begin
          if (accept) begin
            occ_d     = ONE;
            load_h_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_h_in = 1'b1;
          end else if (accept) begin
            occ_d  = FULL;
            load_s = 1'b1;
          end else if (pop) begin
            occ_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            occ_d       = ONE;
            load_h_skid = 1'b1;
          end
        end
        default: occ_d = EMPTY;
      endcase
    end
  end

  // NOTE: payload registers are not reset; every consumer qualifies them with the
  // occupancy state, which is reset, so stale payload is never observable.
  always_ff @(posedge clk) begin
    if (load_h_in)        h_q <= in_entry;
    else if (load_h_skid) h_q <= s_q;
    if (load_s)           s_q <= in_entry;
  end

  // Head fields read as zero when no entry is held, so a bubble never writes.
  assign out_reg_write  = h_valid & h_q.reg_write;
  assign out_mem_to_reg = h_valid & h_q.mem_to_reg;
  assign out_mem_data   = h_valid ? h_q.mem_data   : '0;
  assign out_alu_result = h_valid ? h_q.alu_result : '0;
  assign out_rd         = h_valid ? h_q.rd         : '0;
  assign wb_data        = out_mem_to_reg ? out_mem_data : out_alu_result;

  assign h_wb = h_q.mem_to_reg ? h_q.mem_data : h_q.alu_result;
  assign s_wb = s_q.mem_to_reg ? s_q.mem_data : s_q.alu_result;

  for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
    wb_fwd_match #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
    ) u_match (
      .rs          (fwd_rs[i*REG_AW +: REG_AW]),
      .h_valid     (h_valid),
      .h_reg_write (h_q.reg_write),
      .h_rd        (h_q.rd),
      .h_wb_data   (h_wb),
      .s_valid     (s_valid),
      .s_reg_write (s_q.reg_write),
      .s_rd        (s_q.rd),
      .s_wb_data   (s_wb),
      .hit         (fwd_hit[i]),
      .data        (fwd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule
